// File: rtl/lc3_control.sv
// lc3_control: multi-cycle LC-3 control sequencer (fetch, decode, execute; HALT on unsupported opcodes)
// Ports: clk, reset (async active-low); IR, N/Z/P flags, memRdy in;
//        PC/IR/MAR/MDR/reg/CC load enables, PC/MDR/EAB/ALU selects, bus gates,
//        memory request/write, DR/SR1 addresses, debug state and halted out.
module lc3_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        memRdy,
    output logic        ldPC,
    output logic [1:0]  selPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldReg,
    output logic        ldCC,
    output logic        selMDR,
    output logic        memEn,
    output logic        memWE,
    output logic        gatePC,
    output logic        gateMDR,
    output logic        gateALU,
    output logic        gateMARMUX,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic [1:0]  aluControl,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [3:0]  state,
    output logic        halted
);
    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, ALU, BR, JMP, JSR1,
        JSR2, LEA, ADDR, MEMRD, LDWB, STDATA, MEMWR, HALT
    } state_t;
    state_t cur, nxt;
    logic brTaken;
    logic unusedIr;
    assign unusedIr = ^IR[5:0];
    assign state = cur;
    assign brTaken = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= FETCH1;
        else cur <= nxt;
    end
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH1: nxt = FETCH2;
            FETCH2: nxt = memRdy ? FETCH3 : FETCH2;
            FETCH3: nxt = DECODE;
            DECODE: begin
                case (IR[15:12])
                    4'b0001, 4'b0101, 4'b1001:          nxt = ALU;
                    4'b0000:                            nxt = BR;
                    4'b1100:                            nxt = JMP;
                    4'b0100:                            nxt = JSR1;
                    4'b1110:                            nxt = LEA;
                    4'b0010, 4'b0011, 4'b0110, 4'b0111: nxt = ADDR;
                    default:                            nxt = HALT;
                endcase
            end
            JSR1:   nxt = JSR2;
            ADDR:   nxt = IR[12] ? STDATA : MEMRD;
            MEMRD:  nxt = memRdy ? LDWB : MEMRD;
            STDATA: nxt = MEMWR;
            MEMWR:  nxt = memRdy ? FETCH1 : MEMWR;
            HALT:   nxt = HALT;
            default: nxt = FETCH1;
        endcase
    end
    // Outputs decode the state; holding reset low forces every output to 0,
    // even though the state register already sits in FETCH1.
    always_comb begin
        ldPC = 1'b0;
        selPC = 2'b00;
        ldIR = 1'b0;
        ldMAR = 1'b0;
        ldMDR = 1'b0;
        ldReg = 1'b0;
        ldCC = 1'b0;
        selMDR = 1'b0;
        memEn = 1'b0;
        memWE = 1'b0;
        gatePC = 1'b0;
        gateMDR = 1'b0;
        gateALU = 1'b0;
        gateMARMUX = 1'b0;
        selEAB1 = 1'b0;
        selEAB2 = 2'b00;
        aluControl = 2'b00;
        DR = 3'b000;
        SR1 = 3'b000;
        halted = 1'b0;
        if (reset) begin
            case (cur)
                FETCH1: begin
                    gatePC = 1'b1;
                    ldMAR = 1'b1;
                    ldPC = 1'b1;
                end
                FETCH2, MEMRD: begin
                    memEn = 1'b1;
                    ldMDR = memRdy;
                    selMDR = memRdy;
                end
                FETCH3: begin
                    gateMDR = 1'b1;
                    ldIR = 1'b1;
                end
                ALU: begin
                    gateALU = 1'b1;
                    ldReg = 1'b1;
                    ldCC = 1'b1;
                    DR = IR[11:9];
                    SR1 = IR[8:6];
                    aluControl = IR[15:12] == 4'b0101 ? 2'b01 : IR[15:12] == 4'b1001 ? 2'b10 : 2'b00;
                end
                BR: begin
                    ldPC = brTaken;
                    selPC = brTaken ? 2'b01 : 2'b00;
                    selEAB2 = brTaken ? 2'b10 : 2'b00;
                end
                JMP: begin
                    ldPC = 1'b1;
                    selPC = 2'b01;
                    selEAB1 = 1'b1;
                    SR1 = IR[8:6];
                end
                JSR1: begin
                    gatePC = 1'b1;
                    ldReg = 1'b1;
                    DR = 3'b111;
                end
                // R7 is already written here, so JSRR through R7 lands on the return address.
                JSR2: begin
                    ldPC = 1'b1;
                    selPC = 2'b01;
                    selEAB1 = ~IR[11];
                    selEAB2 = IR[11] ? 2'b11 : 2'b00;
                    SR1 = IR[11] ? 3'b000 : IR[8:6];
                end
                LEA: begin
                    gateMARMUX = 1'b1;
                    ldReg = 1'b1;
                    DR = IR[11:9];
                    selEAB2 = 2'b10;
                end
                // IR[14] separates base+offset6 (LDR/STR) from PC-relative (LD/ST).
                ADDR: begin
                    gateMARMUX = 1'b1;
                    ldMAR = 1'b1;
                    selEAB1 = IR[14];
                    selEAB2 = IR[14] ? 2'b01 : 2'b10;
                    SR1 = IR[14] ? IR[8:6] : 3'b000;
                end
                LDWB: begin
                    gateMDR = 1'b1;
                    ldReg = 1'b1;
                    ldCC = 1'b1;
                    DR = IR[11:9];
                end
                STDATA: begin
                    gateALU = 1'b1;
                    aluControl = 2'b11;
                    SR1 = IR[11:9];
                    ldMDR = 1'b1;
                end
                MEMWR: begin
                    memEn = 1'b1;
                    memWE = 1'b1;
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: directed scoreboard bench for lc3_control
module tb_lc3_control;
    typedef struct packed {
        logic       ldPC;
        logic [1:0] selPC;
        logic       ldIR;
        logic       ldMAR;
        logic       ldMDR;
        logic       ldReg;
        logic       ldCC;
        logic       selMDR;
        logic       memEn;
        logic       memWE;
        logic       gatePC;
        logic       gateMDR;
        logic       gateALU;
        logic       gateMARMUX;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic [1:0] aluControl;
        logic [2:0] DR;
        logic [2:0] SR1;
        logic [3:0] state;
        logic       halted;
    } outs_t;
    typedef struct {
        string tag;
        outs_t v;
    } entry_t;
    logic clk, reset, N, Z, P, memRdy;
    logic [15:0] IR;
    logic ldPC, ldIR, ldMAR, ldMDR, ldReg, ldCC, selMDR, memEn, memWE;
    logic gatePC, gateMDR, gateALU, gateMARMUX, selEAB1, halted;
    logic [1:0] selPC, selEAB2, aluControl;
    logic [2:0] DR, SR1;
    logic [3:0] state;
    outs_t obs;
    entry_t sb[$];
    int nChecks = 0;
    int nPass = 0;
    int nFail = 0;
    lc3_control dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .memRdy(memRdy),
        .ldPC(ldPC), .selPC(selPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .ldReg(ldReg), .ldCC(ldCC), .selMDR(selMDR), .memEn(memEn), .memWE(memWE),
        .gatePC(gatePC), .gateMDR(gateMDR), .gateALU(gateALU), .gateMARMUX(gateMARMUX),
        .selEAB1(selEAB1), .selEAB2(selEAB2), .aluControl(aluControl),
        .DR(DR), .SR1(SR1), .state(state), .halted(halted)
    );
    assign obs = {ldPC, selPC, ldIR, ldMAR, ldMDR, ldReg, ldCC, selMDR, memEn, memWE,
                  gatePC, gateMDR, gateALU, gateMARMUX, selEAB1, selEAB2, aluControl,
                  DR, SR1, state, halted};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic outs_t st(input logic [3:0] s);
        outs_t e = '0;
        e.state = s;
        return e;
    endfunction
    task automatic check();
        entry_t x;
        x = sb.pop_front();
        nChecks++;
        assert (obs === x.v) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
        end
    endtask
    // Push the expectation for this cycle, compare mid-cycle, then advance to the next negedge.
    task automatic step(input outs_t e, input string tag);
        entry_t x;
        x.tag = tag;
        x.v = e;
        sb.push_back(x);
        #1;
        check();
        @(negedge clk);
    endtask
    task automatic fetch(input logic [15:0] ir, input int waits);
        outs_t e;
        IR = ir;
        memRdy = 1'b1;
        e = st(0); e.gatePC = 1; e.ldMAR = 1; e.ldPC = 1;
        step(e, "fetch1");
        memRdy = 1'b0;
        for (int i = 0; i < waits; i++) begin
            e = st(1); e.memEn = 1;
            step(e, "fetch2_wait");
        end
        memRdy = 1'b1;
        e = st(1); e.memEn = 1; e.ldMDR = 1; e.selMDR = 1;
        step(e, "fetch2_rdy");
        e = st(2); e.gateMDR = 1; e.ldIR = 1;
        step(e, "fetch3");
        step(st(3), "decode");
    endtask
    initial begin
        outs_t e;
        reset = 1'b0; IR = 16'h0000; memRdy = 1'b1; N = 0; Z = 0; P = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step('0, "in_reset");
        reset = 1'b1;
        // ADD R1,R1,#1
        fetch(16'h1261, 0);
        e = st(4); e.gateALU = 1; e.ldReg = 1; e.ldCC = 1; e.DR = 3'd1; e.SR1 = 3'd1;
        step(e, "add");
        // AND R0,R1,#2
        fetch(16'h5062, 0);
        e = st(4); e.gateALU = 1; e.ldReg = 1; e.ldCC = 1; e.DR = 3'd0; e.SR1 = 3'd1; e.aluControl = 2'b01;
        step(e, "and");
        // NOT R3,R1
        fetch(16'h967F, 0);
        e = st(4); e.gateALU = 1; e.ldReg = 1; e.ldCC = 1; e.DR = 3'd3; e.SR1 = 3'd1; e.aluControl = 2'b10;
        step(e, "not");
        // BRz taken
        fetch(16'h0405, 0);
        N = 0; Z = 1; P = 0;
        e = st(5); e.ldPC = 1; e.selPC = 2'b01; e.selEAB2 = 2'b10;
        step(e, "brz_taken");
        // BRz not taken with N set
        fetch(16'h0405, 0);
        N = 1; Z = 0; P = 0;
        step(st(5), "brz_not_taken");
        N = 0;
        // JMP R7 with two wait cycles in FETCH2
        fetch(16'hC1C0, 2);
        e = st(6); e.ldPC = 1; e.selPC = 2'b01; e.selEAB1 = 1; e.SR1 = 3'd7;
        step(e, "jmp");
        // JSR PC-relative
        fetch(16'h4805, 0);
        e = st(7); e.gatePC = 1; e.ldReg = 1; e.DR = 3'd7;
        step(e, "jsr1");
        e = st(8); e.ldPC = 1; e.selPC = 2'b01; e.selEAB2 = 2'b11;
        step(e, "jsr2_off11");
        // JSRR R2
        fetch(16'h4080, 0);
        e = st(7); e.gatePC = 1; e.ldReg = 1; e.DR = 3'd7;
        step(e, "jsrr1");
        e = st(8); e.ldPC = 1; e.selPC = 2'b01; e.selEAB1 = 1; e.SR1 = 3'd2;
        step(e, "jsrr2_base");
        // LEA R3
        fetch(16'hE60A, 0);
        e = st(9); e.gateMARMUX = 1; e.ldReg = 1; e.DR = 3'd3; e.selEAB2 = 2'b10;
        step(e, "lea");
        // LD R1 with three wait cycles in MEMRD
        fetch(16'h2203, 0);
        e = st(10); e.gateMARMUX = 1; e.ldMAR = 1; e.selEAB2 = 2'b10;
        step(e, "ld_addr");
        memRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = st(11); e.memEn = 1;
            step(e, "ld_memrd_wait");
        end
        memRdy = 1'b1;
        e = st(11); e.memEn = 1; e.ldMDR = 1; e.selMDR = 1;
        step(e, "ld_memrd_rdy");
        e = st(12); e.gateMDR = 1; e.ldReg = 1; e.ldCC = 1; e.DR = 3'd1;
        step(e, "ld_wb");
        // LDR R5,R2,#5
        fetch(16'h6A85, 0);
        e = st(10); e.gateMARMUX = 1; e.ldMAR = 1; e.selEAB1 = 1; e.selEAB2 = 2'b01; e.SR1 = 3'd2;
        step(e, "ldr_addr");
        e = st(11); e.memEn = 1; e.ldMDR = 1; e.selMDR = 1;
        step(e, "ldr_memrd");
        e = st(12); e.gateMDR = 1; e.ldReg = 1; e.ldCC = 1; e.DR = 3'd5;
        step(e, "ldr_wb");
        // ST R2
        fetch(16'h3403, 0);
        e = st(10); e.gateMARMUX = 1; e.ldMAR = 1; e.selEAB2 = 2'b10;
        step(e, "st_addr");
        e = st(13); e.gateALU = 1; e.aluControl = 2'b11; e.SR1 = 3'd2; e.ldMDR = 1;
        step(e, "st_data");
        e = st(14); e.memEn = 1; e.memWE = 1;
        step(e, "st_memwr");
        // STR R5,R2,#5 then reset while the write is still waiting
        fetch(16'h7A85, 0);
        e = st(10); e.gateMARMUX = 1; e.ldMAR = 1; e.selEAB1 = 1; e.selEAB2 = 2'b01; e.SR1 = 3'd2;
        step(e, "str_addr");
        e = st(13); e.gateALU = 1; e.aluControl = 2'b11; e.SR1 = 3'd5; e.ldMDR = 1;
        step(e, "str_data");
        memRdy = 1'b0;
        e = st(14); e.memEn = 1; e.memWE = 1;
        step(e, "str_memwr_wait");
        step(e, "str_memwr_wait2");
        reset = 1'b0;
        step('0, "reset_in_memwr");
        step('0, "reset_hold");
        reset = 1'b1;
        // TRAP: unsupported, parks in HALT regardless of memRdy and flags
        fetch(16'hF025, 0);
        e = st(15); e.halted = 1;
        for (int i = 0; i < 22; i++) begin
            memRdy = 1'($urandom_range(0, 1));
            {N, Z, P} = 3'($urandom_range(0, 7));
            step(e, "halt_hold");
        end
        reset = 1'b0;
        step('0, "reset_from_halt");
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/lc3_control.md
# lc3_control

Multi-cycle control sequencer for the LC-3 datapath. It drives the PC register's load and next-PC select, and the IR, MAR, MDR, register-file, condition-code, bus-gate and memory handshake controls. It steps each instruction through fetch, decode and execute states. Unsupported opcodes park it in a HALT state until reset.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IR  in  16  current instruction register contents
- N, Z, P  in  1 each  condition-code flags
- memRdy  in  1  memory completes access this cycle
- ldPC  out  1  PC register load enable
- selPC  out  2  PC mux: 00 PC+1, 01 EAB, 10 bus (11 never driven)
- ldIR, ldMAR, ldMDR, ldReg, ldCC  out  1 each  load enables
- selMDR  out  1  MDR source: 1 memory, 0 bus
- memEn, memWE  out  1 each  memory request, write qualifier
- gatePC, gateMDR, gateALU, gateMARMUX  out  1 each  bus drivers (at most one high)
- selEAB1  out  1  EAB base: 0 PC, 1 SR1
- selEAB2  out  2  EAB offset: 00 zero, 01 off6, 10 off9, 11 off11
- aluControl  out  2  00 ADD, 01 AND, 10 NOT, 11 pass A
- DR, SR1  out  3 each  register-file destination and source-1 addresses
- state  out  4  current state code (debug)
- halted  out  1  high in HALT

## Operation
Unlisted outputs are 0 in every state.
- FETCH1 (0): gatePC, ldMAR, ldPC, selPC=00. Go to FETCH2.
- FETCH2 (1): memEn. Hold until memRdy=1. On that cycle drive ldMDR with selMDR=1, then go to FETCH3.
- FETCH3 (2): gateMDR, ldIR. Go to DECODE.
- DECODE (3): no outputs. Dispatch on IR[15:12]:
  - 0001, 0101, 1001 → ALU
  - 0000 → BR
  - 1100 → JMP
  - 0100 → JSR1
  - 1110 → LEA
  - 0010, 0011, 0110, 0111 → ADDR
  - all others → HALT
- ALU (4): gateALU, ldReg, ldCC, DR=IR[11:9], SR1=IR[8:6]. aluControl is 00 for 0001, 01 for 0101, 10 for 1001. Go to FETCH1.
- BR (5): if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), drive ldPC, selPC=01, selEAB1=0, selEAB2=10. Otherwise no outputs. Go to FETCH1.
- JMP (6): ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6]. Go to FETCH1.
- JSR1 (7): gatePC, ldReg, DR=111. Go to JSR2.
- JSR2 (8): ldPC, selPC=01.
  - IR[11]=1: selEAB1=0, selEAB2=11.
  - IR[11]=0: selEAB1=1, selEAB2=00, SR1=IR[8:6].
  - Go to FETCH1.
  - JSRR with base R7 jumps to the new R7 (the return address). This is a defined behaviour.
- LEA (9): gateMARMUX, ldReg, DR=IR[11:9], selEAB1=0, selEAB2=10. No CC update. Go to FETCH1.
- ADDR (10): gateMARMUX, ldMAR.
  - IR[14]=0: selEAB1=0, selEAB2=10.
  - IR[14]=1: selEAB1=1, selEAB2=01, SR1=IR[8:6].
  - Next state is MEMRD if IR[12]=0, else STDATA.
- MEMRD (11): memEn. Hold until memRdy=1. On that cycle drive ldMDR with selMDR=1, then go to LDWB.
- LDWB (12): gateMDR, ldReg, ldCC, DR=IR[11:9]. Go to FETCH1.
- STDATA (13): gateALU, aluControl=11, SR1=IR[11:9], ldMDR, selMDR=0. Go to MEMWR.
- MEMWR (14): memEn, memWE. Hold until memRdy=1, then go to FETCH1.
- HALT (15): halted=1, no other outputs. Stays until reset.

Outputs are a Moore decode of state, plus IR, flags and memRdy where noted above.

## Timing
- Reset low: state=FETCH1 immediately (asynchronous), and all outputs are forced to 0, including outputs derived from FETCH1.
- Reset release: the first rising edge after reset returns high executes FETCH1.
- Cycles per instruction with memRdy held 1:
  - ALU, BR, JMP, LEA: 5
  - JSR/JSRR: 6
  - LD, LDR, ST, STR: 7
- Each cycle memRdy is low in FETCH2, MEMRD or MEMWR adds 1 cycle.
- A memory state lasts at least 1 cycle.
- memEn stays continuously high through the wait.
- ldMDR pulses exactly once per read, on the memRdy cycle.
- memRdy is ignored outside the memory states.
- Reset asserted mid-access drops memEn and memWE asynchronously. No partial write completes from the controller's side.
- The flag inputs N/Z/P are sampled only in the BR cycle.

## Test plan
- Reset low for 3 cycles, then release with memRdy=1:
  - During reset: all outputs 0, state=0.
  - Cycle 1 after release: gatePC=ldMAR=ldPC=1, selPC=00.
  - Cycle 2: state=1, memEn=1.
- IR=0x1261 (ADD R1,R1,#1) → cycle 5 is state=4 with ldReg=ldCC=1, aluControl=00, DR=001, SR1=001. Cycle 6 is FETCH1.
- IR=0x0405 (BRz):
  - With Z=1: BR cycle drives ldPC=1, selPC=01, selEAB2=10.
  - With Z=0, N=1: ldPC=0. Returns to FETCH1 either way.
- IR=0x2203 (LD) with memRdy low for 3 cycles in MEMRD → memEn high for 4 cycles, ldMDR only on the 4th. Total 10 cycles, with LDWB ldReg=1 and DR=001.
- IR=0x3403 (ST), memRdy=1 → STDATA drives aluControl=11, SR1=010, ldMDR=1, selMDR=0. Next cycle has memEn=memWE=1. 7 cycles total.
- IR=0xF025 (TRAP) → HALT, halted=1 for 20+ cycles with no loads. Separately, reset pulsed during MEMWR with memRdy=0 drops memWE immediately, and the controller restarts at FETCH1.
